io_port_fifo_bank: RTL
======================

Name: io_port_fifo_bank

Overview:
- Parametrised bank of IO_PORT_COUNT independent FIFO channels in each direction.
- Sits between external valid/ready streams and the processor's Empty/Full-bit I/O port interface (io_read_EF / io_read_data / io_rden and io_write_EF / io_write_data / io_wren).
- Decouples producers and consumers from the processor's threaded issue timing. Each port gets its own buffering, with depth and width set at elaboration.

Parameters:
- WORD_WIDTH, 36, data word width per port.
- IO_PORT_COUNT, 4, number of ports; the bank holds one read FIFO and one write FIFO per port.
- FIFO_DEPTH, 8, entries per FIFO; must be a power of two, 2 or more.
- FIFO_ADDR_WIDTH, 3, log2(FIFO_DEPTH).
- FIFO_RAMSTYLE, "MLAB", synthesis RAM style attribute for the storage arrays.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ext_in_valid  in  IO_PORT_COUNT  external producer has a word for port p.
- ext_in_ready  out  IO_PORT_COUNT  read FIFO p can accept a word (= ~full).
- ext_in_data  in  IO_PORT_COUNT*WORD_WIDTH  producer words; port p occupies bits [p*W +: W].
- io_read_EF  out  IO_PORT_COUNT  1 = read FIFO p holds data.
- io_read_data  out  IO_PORT_COUNT*WORD_WIDTH  head word of read FIFO p (first-word fall-through).
- io_rden  in  IO_PORT_COUNT  processor pops read FIFO p.
- io_write_EF  out  IO_PORT_COUNT  1 = write FIFO p is full.
- io_write_data  in  IO_PORT_COUNT*WORD_WIDTH  processor write words.
- io_wren  in  IO_PORT_COUNT  processor pushes into write FIFO p.
- ext_out_valid  out  IO_PORT_COUNT  write FIFO p holds data.
- ext_out_ready  in  IO_PORT_COUNT  external consumer accepts port p.
- ext_out_data  out  IO_PORT_COUNT*WORD_WIDTH  head word of write FIFO p.
- Conditional: occupancy  out  IO_PORT_COUNT*2*(FIFO_ADDR_WIDTH+1)  see Optional Feature.

Behaviour:
- Each FIFO has read/write pointers of FIFO_ADDR_WIDTH+1 bits.
  - empty = pointers equal.
  - full = address bits equal and MSBs differ.
  - Pointers wrap naturally modulo 2*FIFO_DEPTH.
- Reset (reset_n low, async) clears all pointers. Values while reset is asserted:
  - io_read_EF = 0, ext_out_valid = 0.
  - ext_in_ready = 1, io_write_EF = 0.
  - Data outputs are don't-care; storage is not cleared.
- Reset asserted mid-transfer discards all buffered words. First legal push is on the first rising edge after reset_n is deasserted.
- Read direction, port p:
  - Push when ext_in_valid[p] & ext_in_ready[p].
  - Pop when io_rden[p] & io_read_EF[p].
- Write direction, port p:
  - Push when io_wren[p] & ~io_write_EF[p].
  - Pop when ext_out_valid[p] & ext_out_ready[p].
- Latency: a word pushed at edge t appears at the FIFO head, with its EF/valid bit set, in the cycle after edge t. Full-to-head latency is 1 cycle.
- Head data is combinational from storage at the read pointer. It is stable while not popped.
- Simultaneous push and pop in one cycle:
  - On a non-empty, non-full FIFO, both occur and occupancy is unchanged.
  - When full, the pop occurs, but the push is blocked because ready/EF was computed before the pop. No bypass.
  - When empty, the push occurs and the pop is blocked (no fall-through bypass).
- io_rden on an empty FIFO and io_wren on a full FIFO are ignored: no pointer change and no data corruption. The processor is required to annul such instructions.
- Ports are fully independent; no arbitration between them.

Optional Feature:
- Macro: IO_FIFO_OCCUPANCY_EN.
- Defined: the occupancy port exists. Per port p, the field layout is:
  - Low field: read FIFO count.
  - High field: write FIFO count.
  - Each count is wptr - rptr, modulo 2^(FIFO_ADDR_WIDTH+1), range 0..FIFO_DEPTH.
  - Counts are registered and update on the same edge as the pointers. Reset value is 0.
- Undefined: the port and its counting logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then check idle outputs: all io_read_EF = 0, ext_in_ready = 1, io_write_EF = 0, ext_out_valid = 0.
- Read fill and drain, port 0, default parameters:
  - Push 0x1, 0x2, ..., 0x8 on 8 consecutive cycles.
  - Expect ext_in_ready[0] = 0 after the 8th push; a 9th valid word is not accepted.
  - Pop 8 times; io_read_data shows 0x1..0x8 in order, then io_read_EF[0] = 0.
- Write side with backpressure, port 2:
  - io_wren on 9 cycles with data 0xA0..0xA8 and ext_out_ready = 0.
  - Expect io_write_EF[2] = 1 after 8 pushes; 0xA8 is dropped.
  - Release ready; ext_out_data shows 0xA0..0xA7.
- Simultaneous events:
  - Port 1 holding 3 words, push and pop in the same cycle: count stays 3 and order is preserved.
  - Full FIFO with push and pop in the same cycle: count becomes 7.
  - Empty FIFO with push and pop in the same cycle: count becomes 1.
- Pointer wrap: stream 40 words through port 3 with random valid/ready. The output sequence equals the input sequence, with no loss or duplication.
- Reset mid-operation: assert reset_n low while port 0 holds 5 words. Outputs go to reset values immediately, asynchronously. After release, io_read_EF[0] = 0; with IO_FIFO_OCCUPANCY_EN defined, occupancy reads 0.

Source files
------------

// File: rtl/io_port_fifo_bank_if.sv
// io_port_fifo_bank_if: valid/ready stream and Empty/Full-bit I/O port signals
// shared between the FIFO bank and its producers/consumers.
interface io_port_fifo_bank_if #(
  parameter int WORD_WIDTH    = 36,
  parameter int IO_PORT_COUNT = 4
) ();
  logic [IO_PORT_COUNT-1:0]            ext_in_valid, ext_in_ready, io_read_EF, io_rden;
  logic [IO_PORT_COUNT-1:0]            io_write_EF, io_wren, ext_out_valid, ext_out_ready;
  logic [IO_PORT_COUNT*WORD_WIDTH-1:0] ext_in_data, io_read_data, io_write_data, ext_out_data;
  modport slave (
    input  ext_in_valid, ext_in_data, io_rden, io_write_data, io_wren, ext_out_ready,
    output ext_in_ready, io_read_EF, io_read_data, io_write_EF, ext_out_valid, ext_out_data
  );
  modport master (
    output ext_in_valid, ext_in_data, io_rden, io_write_data, io_wren, ext_out_ready,
    input  ext_in_ready, io_read_EF, io_read_data, io_write_EF, ext_out_valid, ext_out_data
  );
endinterface

// File: rtl/io_port_fifo_bank.sv
// io_port_fifo_bank: per-port read and write FWFT FIFOs between valid/ready streams and E/F I/O ports.
// Optional registered occupancy output under IO_FIFO_OCCUPANCY_EN.
module io_port_fifo_bank #(
  parameter int WORD_WIDTH      = 36,
  parameter int IO_PORT_COUNT   = 4,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3,
  parameter     FIFO_RAMSTYLE   = "MLAB"
) (
  input logic clock,
  input logic reset_n,
`ifdef IO_FIFO_OCCUPANCY_EN
  output logic [IO_PORT_COUNT*2*(FIFO_ADDR_WIDTH+1)-1:0] occupancy,
`endif
  io_port_fifo_bank_if.slave bus
);
  localparam int W  = WORD_WIDTH;
  localparam int P  = IO_PORT_COUNT;
  localparam int AW = FIFO_ADDR_WIDTH;
  localparam int N  = 2 * P;
  logic [N-1:0] push, pop, empty, full;
  logic [W-1:0] din [N];
  logic [W-1:0] dout [N];
  logic [AW:0]  cnt [N];
  genvar p, f;
  // FIFO index p is the read FIFO of port p, index P+p its write FIFO
  for (p = 0; p < P; p++) begin : g_port
    assign push[p]   = bus.ext_in_valid[p] & ~full[p];
    assign pop[p]    = bus.io_rden[p] & ~empty[p];
    assign push[P+p] = bus.io_wren[p] & ~full[P+p];
    assign pop[P+p]  = bus.ext_out_ready[p] & ~empty[P+p];
    assign din[p]    = bus.ext_in_data[p*W +: W];
    assign din[P+p]  = bus.io_write_data[p*W +: W];
    assign bus.ext_in_ready[p]          = ~full[p];
    assign bus.io_read_EF[p]            = ~empty[p];
    assign bus.io_read_data[p*W +: W]   = dout[p];
    assign bus.io_write_EF[p]           = full[P+p];
    assign bus.ext_out_valid[p]         = ~empty[P+p];
    assign bus.ext_out_data[p*W +: W]   = dout[P+p];
`ifdef IO_FIFO_OCCUPANCY_EN
    assign occupancy[p*2*(AW+1) +: 2*(AW+1)] = {cnt[P+p], cnt[p]};
`endif
  end
  for (f = 0; f < N; f++) begin : g_fifo
    (* ramstyle = FIFO_RAMSTYLE *) logic [W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    assign empty[f] = wptr_q == rptr_q;
    assign full[f]  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign dout[f]  = mem_q[rptr_q[AW-1:0]];
    always_comb begin
      wptr_d = wptr_q + (AW+1)'(push[f]);
      rptr_d = rptr_q + (AW+1)'(pop[f]);
    end
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        wptr_q <= wptr_d;
        rptr_q <= rptr_d;
      end
    end
    // storage is deliberately left unreset so it can map onto RAM
    always_ff @(posedge clock) begin
      if (push[f]) mem_q[wptr_q[AW-1:0]] <= din[f];
    end
`ifdef IO_FIFO_OCCUPANCY_EN
    logic [AW:0] cnt_q, cnt_d;
    assign cnt_d = wptr_d - rptr_d;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    assign cnt[f] = cnt_q;
`else
    assign cnt[f] = '0;
`endif
  end
endmodule
